reset_pulse_gen: RTL

- Source side of the reset path: collects reset requests and emits a clean, stretched, active-high reset pulse.
- Request sources are power-on, a software reset strobe from the register interface, and a debounced external reset button.
- The pulse feeds the async reset input of each clock domain's reset synchronizer.
- Reports which source caused the reset, a busy flag, and a one-cycle completion strobe.

---
 rtl/reset_pulse_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/reset_pulse_gen.sv
// Reset request collector: debounces the external button, merges it with the
// software strobe and emits a stretched, registered active-high reset pulse.
module reset_pulse_gen #(
   parameter int unsigned HOLD_CYCLES     = 16,
   parameter int unsigned RECOVERY_CYCLES = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sw_req,
   input  logic       btn_n,
   output logic       rst_out,
   output logic       busy,
   output logic       done,
   output logic [1:0] cause
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned RW = $clog2(RECOVERY_CYCLES + 1);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
   localparam logic [RW-1:0] REC_LAST  = RW'(RECOVERY_CYCLES - 1);
   localparam logic [RW-1:0] REC_MAX   = RW'(RECOVERY_CYCLES);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RECOVER = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // ---------------- button synchronizer and debouncer ----------------
   logic          sync1_q, sync2_q;
   logic          pressed_q, pressed_d;
   logic [DW-1:0] db_q, db_d;
   logic          btn_req_q, btn_req_d;
   logic          sample_pressed;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         pressed_q <= 1'b0;
         db_q      <= '0;
         btn_req_q <= 1'b0;
      end else begin
         sync1_q   <= btn_n;
         sync2_q   <= sync1_q;
         pressed_q <= pressed_d;
         db_q      <= db_d;
         btn_req_q <= btn_req_d;
      end
   end

   // The counter is cleared on the flip, so it never exceeds DEB_LAST.
   always_comb begin
      sample_pressed = ~sync2_q;
      pressed_d      = pressed_q;
      db_d           = '0;
      btn_req_d      = 1'b0;
      if (sample_pressed != pressed_q) begin
         if (db_q >= DEB_LAST) begin
            pressed_d = sample_pressed;
            btn_req_d = sample_pressed;
         end else begin
            db_d = db_q + 1'b1;
         end
      end
   end

   // ---------------- sequencing FSM ----------------
   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [RW-1:0] rec_q, rec_d;
   logic [1:0]    cause_q, cause_d;
   logic          rst_out_q, busy_q, done_q;
   logic          req;
   logic [1:0]    req_bits;

   always_comb begin
      req_bits = {btn_req_q, sw_req};
      req      = |req_bits;
      state_d  = state_q;
      hold_d   = hold_q;
      rec_d    = rec_q;
      cause_d  = cause_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (req) begin
               state_d = ST_ASSERT;
               hold_d  = '0;
               cause_d = req_bits;
            end
         end
         ST_ASSERT: begin
            // A re-request counts its own cycle as the first of the new hold.
            if (req) begin
               hold_d  = HW'(1);
               cause_d = cause_q | req_bits;
            end else if (hold_q >= HOLD_LAST) begin
               state_d = ST_RECOVER;
               rec_d   = '0;
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_RECOVER: begin
            if (req) begin
               state_d = ST_ASSERT;
               hold_d  = '0;
               cause_d = cause_q | req_bits;
            end else if (rec_q >= REC_LAST) begin
               state_d = ST_DONE;
            end else if (rec_q != REC_MAX) begin
               rec_d = rec_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_ASSERT;
         hold_q    <= '0;
         rec_q     <= '0;
         cause_q   <= 2'b00;
         rst_out_q <= 1'b1;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         rec_q     <= rec_d;
         cause_q   <= cause_d;
         rst_out_q <= (state_d == ST_ASSERT);
         busy_q    <= (state_d == ST_ASSERT) || (state_d == ST_RECOVER);
         done_q    <= (state_d == ST_DONE);
      end
   end

   assign rst_out = rst_out_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign cause   = cause_q;

endmodule
